reg_read_port: RTL
==================

// Module: reg_read_port
// PURPOSE
//   Handshaked read port for the register file built from FF instances.
//   Accepts read requests (valid/ready) and selects a word from the flattened
//   register Q bus. Bypasses a same-cycle write to the requested register.
//   Returns data through a 2-entry response buffer with 1-cycle latency.
//   Sits between the register-file storage and any consumer that can stall.
// PARAMETERS
//   WIDTH     32  data width of each register
//   NREGS     32  number of registers in the file
//   ADDR_W     5  address width; must satisfy 2**ADDR_W >= NREGS
//   ZERO_REG   1  1: address 0 always reads 0 and is never bypassed
// PORTS
//   clk        in   1              clock, rising edge
//   reset      in   1              asynchronous, active-low
//   req_valid  in   1              read request present
//   req_ready  out  1              request accepted when req_valid & req_ready
//   req_addr   in   ADDR_W         register index to read
//   regs_q     in   NREGS*WIDTH    flattened FF outputs; reg i = [i*WIDTH +: WIDTH]
//   wr_en      in   1              write strobe of the register file, same clk
//   wr_addr    in   ADDR_W         register being written this cycle
//   wr_data    in   WIDTH          data being written this cycle
//   rsp_valid  out  1              response word available
//   rsp_ready  in   1              consumer takes response when rsp_valid & rsp_ready
//   rsp_data   out  WIDTH          read data
//   rsp_addr   out  ADDR_W         address the response belongs to
//   rsp_err    out  1              1 = req_addr >= NREGS; rsp_data is 0
// BEHAVIOUR
//   - Reset (reset=0, async): buffer emptied; count=0.
//     rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0. req_ready=0 while reset
//     is low, and =1 on the first cycle after release.
//   - Buffer: 2-entry FIFO of {data, addr, err}. count is 0..2.
//     req_ready = (count != 2). It has no combinational path from rsp_ready.
//   - Push: on a clk edge where req_valid & req_ready:
//       err = (req_addr >= NREGS); data = 0 if err, or if ZERO_REG and addr==0.
//       Otherwise, if wr_en & wr_addr==req_addr, data = wr_data (bypass:
//       new value, not the stale Q). Otherwise data = regs_q word req_addr.
//   - Latency: a request accepted at edge N is visible on rsp_* after edge N,
//     i.e. in cycle N+1, provided the buffer was empty.
//   - Pop: on an edge where rsp_valid & rsp_ready, the head entry is removed.
//   - Simultaneous push and pop: count is unchanged and order is preserved.
//     With count=1, sustained throughput is 1 response per clk.
//   - rsp_* show the head entry. They are stable while rsp_valid & !rsp_ready.
//     rsp_data/addr/err are 0 when count=0.
//   - Snapshot semantics: a buffered entry is NOT updated by later writes to
//     the same register.
//   - wr_en is used only for bypass. This block never drives the register file.
//   - Reset mid-operation: buffered responses are discarded with no partial
//     output. The next request after release behaves as the first.
// TESTING
//   1 Reset: hold reset=0 with random inputs -> rsp_valid=0, rsp_data=0,
//     req_ready=0. Release -> req_ready=1.
//   2 Basic read: reg 7 = 0xDEADBEEF. Request addr 7 with rsp_ready=1 ->
//     next cycle rsp_valid=1, rsp_data=0xDEADBEEF, rsp_addr=7.
//   3 Bypass: reg 3 = 0x11. In the same cycle, req addr 3 and wr_en=1,
//     wr_addr=3, wr_data=0x22 -> rsp_data=0x22. Same test on addr 0 with
//     ZERO_REG=1 -> 0.
//   4 Backpressure: rsp_ready=0; issue reads of 1, 2, 3 -> first two accepted,
//     req_ready=0 on the third. rsp_data holds reg1. Raise rsp_ready -> reg1,
//     reg2, then reg3, in order.
//   5 Streaming: rsp_ready=1; 16 back-to-back requests addr 0..15 ->
//     16 consecutive responses with no gap. A write to reg 5 after it is
//     buffered does not alter the buffered value.
//   6 Out of range (NREGS=24, ADDR_W=5): request addr 30 -> rsp_err=1,
//     rsp_data=0. Assert reset while count=2 -> buffer empties and rsp_valid=0.

Source files
------------

// File: rtl/reg_read_port.sv
// Handshaked read port for a flip-flop register file.
// Selects one word of the flattened Q bus, forwards a same-cycle write to the
// requested register, and returns {data, addr, err} through a 2-entry buffer.
// A request accepted on one edge shows on rsp_* in the following cycle.
module reg_read_port #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [NREGS*WIDTH-1:0] regs_q,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ADDR_W-1:0]      rsp_addr,
    output logic                   rsp_err
);

    // Register count widened by one bit so the range test also works when
    // NREGS equals 2**ADDR_W.
    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NREGS);

    logic [WIDTH-1:0]  reg_words [NREGS];

    logic [WIDTH-1:0]  mem_data_reg [2];
    logic [ADDR_W-1:0] mem_addr_reg [2];
    logic              mem_err_reg  [2];

    logic [1:0]        count_reg, count_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;
    logic              req_ready_reg;

    logic              push, pop;
    logic              push_err;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  push_data;

    // Unflatten the Q bus into one word per register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
            assign reg_words[gi] = regs_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign push = req_valid & req_ready_reg;
    assign pop  = rsp_valid & rsp_ready;

    // Form the word to capture: out-of-range and the hardwired zero register
    // read 0, a same-cycle write wins over the stale Q value.
    always_comb begin
        rd_word   = '0;
        push_err  = ({1'b0, req_addr} >= NREGS_W);
        for (int i = 0; i < NREGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                rd_word = reg_words[i];
            end
        end
        if (push_err || ((ZERO_REG != 0) && (req_addr == '0))) begin
            push_data = '0;
        end else if (wr_en && (wr_addr == req_addr)) begin
            push_data = wr_data;
        end else begin
            push_data = rd_word;
        end
    end

    // Occupancy and pointer updates; push and pop together leave count alone.
    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg ^ push;
        rd_ptr_next = rd_ptr_reg ^ pop;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Control state; req_ready is registered so it never depends on rsp_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            req_ready_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            req_ready_reg <= (count_next != 2'd2);
        end
    end

    // Entry storage; contents are only observable through a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_reg[wr_ptr_reg] <= push_data;
            mem_addr_reg[wr_ptr_reg] <= req_addr;
            mem_err_reg[wr_ptr_reg]  <= push_err;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = (count_reg != 2'd0);
    assign rsp_data  = rsp_valid ? mem_data_reg[rd_ptr_reg] : '0;
    assign rsp_addr  = rsp_valid ? mem_addr_reg[rd_ptr_reg] : '0;
    assign rsp_err   = rsp_valid ? mem_err_reg[rd_ptr_reg]  : 1'b0;

endmodule
